// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, paces reads of instruction memory and queues fetched words for decode.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky Fault and halts fetch.
module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          WAIT_CYCLES = 2,
   parameter int          BUF_DEPTH   = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   output logic [63:0] Address,
   input  logic [31:0] Data,
   output logic [31:0] InstrOut,
   output logic [63:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
   input  logic        Redirect,
   input  logic [63:0] RedirectPC,
   output logic        Fault
);

   localparam int                PTR_W     = $clog2(BUF_DEPTH);
   localparam int                CNT_W     = $clog2(BUF_DEPTH + 1);
   localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {S_FETCH, S_FULL, S_HALT} state_e;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_e            state_q, state_d;
   logic [63:0]       pc_q, pc_d;
   logic [3:0]        wait_q, wait_d;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q, rd_next;
   logic [CNT_W-1:0]  count_q, count_d;
   entry_t            head_q, head_d;
   logic              valid_q;
   entry_t            mem_q [BUF_DEPTH];

   logic wait_last, pop, do_pop, slot_free, take_redirect, redirect_bad;
   logic push, flush, load_redirect, set_fault;

   assign wait_last     = (wait_q == WAIT_LAST);
   assign pop           = valid_q & InstrReady;
   // A slot being popped on this edge is free for the word captured on the same edge.
   assign slot_free     = (count_q != DEPTH_C) | pop;
   assign take_redirect = Redirect & (state_q != S_HALT);
   assign do_pop        = pop & ~take_redirect;
   assign rd_next       = rd_ptr_q + PTR_W'(1);

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   assign redirect_bad = Redirect & (RedirectPC[1:0] != 2'b00);
   assign Fault        = fault_q;
`else
   assign redirect_bad = 1'b0;
   assign Fault        = 1'b0;
`endif

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: if (wait_last && !slot_free) state_d = S_FULL;
         S_FULL:  if (slot_free)               state_d = S_FETCH;
         default: state_d = S_HALT;
      endcase
      if (take_redirect) state_d = redirect_bad ? S_HALT : S_FETCH;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      push          = 1'b0;
      flush         = 1'b0;
      load_redirect = 1'b0;
      set_fault     = 1'b0;
      if (take_redirect) begin
         flush         = 1'b1;
         set_fault     = redirect_bad;
         load_redirect = ~redirect_bad;
      end else begin
         unique case (state_q)
            S_FETCH: push = wait_last & slot_free;
            S_FULL:  push = slot_free;
            default: push = 1'b0;
         endcase
      end

      pc_d   = pc_q;
      wait_d = wait_q;
      if (load_redirect)               pc_d = RedirectPC & ~64'h3;
      else if (push)                   pc_d = pc_q + 64'd4;
      if (take_redirect || push)       wait_d = '0;
      else if (state_q == S_FETCH && !wait_last) wait_d = wait_q + 4'd1;
   end

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
         if (push && (count_q - CNT_W'(do_pop)) == '0) head_d = {pc_q, Data};
         else if (do_pop && count_q > CNT_W'(1))       head_d = mem_q[rd_next];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc_q     <= RESET_PC;
         wait_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         wait_q  <= wait_d;
         count_q <= count_d;
         head_q  <= head_d;
         valid_q <= (count_d != '0);
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (do_pop) rd_ptr_q <= rd_next;
            if (push)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
      end
   end

   // NOTE: storage array has no reset; only slots behind a valid count are ever read.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= {pc_q, Data};
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset)          fault_q <= 1'b0;
      else if (set_fault) fault_q <= 1'b1;
   end
`endif

   assign Address    = pc_q;
   assign InstrOut   = head_q.instr;
   assign InstrPC    = head_q.pc;
   assign InstrValid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory model feeds Data and a scoreboard queue holds the
// expected {PC, word} stream for every fetch start (reset release or redirect).
module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [63:0] Address;
   logic [31:0] Data;
   logic [31:0] InstrOut;
   logic [63:0] InstrPC;
   logic        InstrValid;
   logic        InstrReady;
   logic        Redirect;
   logic [63:0] RedirectPC;
   logic        Fault;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   instr_fetch_unit #(.RESET_PC(64'h0), .WAIT_CYCLES(2), .BUF_DEPTH(2)) dut (
      .CLK(CLK), .Reset(Reset), .Address(Address), .Data(Data),
      .InstrOut(InstrOut), .InstrPC(InstrPC), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .Fault(Fault)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h00:  return 32'hF84003E9;
         64'h04:  return 32'hF84083EA;
         64'h08:  return 32'hF84103EB;
         64'h28:  return 32'h17FFFFFD;
         64'h2C:  return 32'hF80203ED;
         64'h30:  return 32'hF84203ED;
         default: return {16'hC0DE, a[17:2]};
      endcase
   endfunction

   assign Data = mem_word(Address);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic start_stream(input logic [63:0] pc, input int n);
      logic [63:0] p;
      p = pc;
      sb_q.delete();
      for (int i = 0; i < n; i++) begin
         sb_q.push_back('{pc: p, instr: mem_word(p)});
         p = p + 64'd4;
      end
   endtask

   task automatic pulse_redirect(input logic [63:0] pc);
      Redirect   = 1'b1;
      RedirectPC = pc;
      @(posedge CLK);
      #1;
      Redirect   = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge CLK);
      #1;
      check(tag, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20 && !InstrValid; i++) begin
         @(posedge CLK);
         #1;
      end
      check(tag, 64'(InstrValid), 64'd1);
   endtask

   // Pops happen on the next rising edge when valid & ready hold here; a redirect discards that pop.
   always @(negedge CLK) begin
      if (!Reset && InstrValid && InstrReady && !Redirect && sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("pop_pc", InstrPC, e.pc);
         check("pop_instr", 64'(InstrOut), 64'(e.instr));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] held;
      Reset = 1'b1; InstrReady = 1'b1; Redirect = 1'b0; RedirectPC = '0;

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_addr", Address, 64'h0);
      check("rst_valid", 64'(InstrValid), 64'd0);
      check("rst_instr", 64'(InstrOut), 64'd0);
      check("rst_pc", InstrPC, 64'd0);
      check("rst_fault", 64'(Fault), 64'd0);

      // Sequential stream, latency and throughput
      start_stream(64'h0, 8);
      @(negedge CLK); Reset = 1'b0;
      @(posedge CLK); #1;
      check("lat_edge1_valid", 64'(InstrValid), 64'd0);
      @(posedge CLK); #1;
      check("lat_edge2_valid", 64'(InstrValid), 64'd1);
      check("lat_edge2_addr", Address, 64'h4);
      repeat (13) @(posedge CLK);
      #1;
      check("rate_left_1", 64'(sb_q.size()), 64'd1);
      repeat (2) @(posedge CLK);
      #1;
      check("rate_left_0", 64'(sb_q.size()), 64'd0);

      // Backpressure fills the buffer, then resumes without gap or duplicate
      InstrReady = 1'b0;
      start_stream(64'h0, 6);
      pulse_redirect(64'h0);
      repeat (8) @(posedge CLK);
      #1;
      check("full_addr", Address, 64'h8);
      check("full_pc", InstrPC, 64'h0);
      check("full_instr", 64'(InstrOut), 64'hF84003E9);
      repeat (3) @(posedge CLK);
      #1;
      check("full_addr_hold", Address, 64'h8);
      check("full_instr_hold", 64'(InstrOut), 64'hF84003E9);
      InstrReady = 1'b1;
      wait_drain("full_drain");

      // Redirect while buffer holds 0x10, 0x14
      InstrReady = 1'b0;
      pulse_redirect(64'h10);
      repeat (8) @(posedge CLK);
      #1;
      check("pre_redir_addr", Address, 64'h18);
      check("pre_redir_pc", InstrPC, 64'h10);
      start_stream(64'h28, 2);
      pulse_redirect(64'h28);
      check("redir_flush_valid", 64'(InstrValid), 64'd0);
      InstrReady = 1'b1;
      wait_drain("redir_drain");

      // Redirect on an edge with a scheduled push and a pop
      InstrReady = 1'b0;
      pulse_redirect(64'h40);
      wait_valid("coll_first_valid");
      check("coll_head_pc", InstrPC, 64'h40);
      @(posedge CLK); #1;
      InstrReady = 1'b1;
      start_stream(64'h80, 3);
      pulse_redirect(64'h80);
      check("coll_flush_valid", 64'(InstrValid), 64'd0);
      check("coll_addr", Address, 64'h80);
      wait_drain("coll_drain");

      // PC wraps past the top of the address space
      InstrReady = 1'b0;
      start_stream(64'hFFFF_FFFF_FFFF_FFFC, 3);
      pulse_redirect(64'hFFFF_FFFF_FFFF_FFFC);
      InstrReady = 1'b1;
      wait_drain("wrap_drain");

      // Reset mid-wait with one entry queued
      InstrReady = 1'b0;
      pulse_redirect(64'h100);
      wait_valid("mid_valid");
      @(posedge CLK); #1;
      Reset = 1'b1;
      #1;
      check("async_rst_addr", Address, 64'h0);
      check("async_rst_valid", 64'(InstrValid), 64'd0);
      start_stream(64'h0, 3);
      InstrReady = 1'b1;
      @(negedge CLK); Reset = 1'b0;
      wait_drain("rst_refetch_drain");

      // Misaligned redirect target
      InstrReady = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      sb_q.delete();
      held = Address;
      pulse_redirect(64'h32);
      check("align_fault", 64'(Fault), 64'd1);
      check("align_addr_frozen", Address, held);
      check("align_flush_valid", 64'(InstrValid), 64'd0);
      pulse_redirect(64'h34);
      repeat (6) @(posedge CLK);
      #1;
      check("halt_addr_frozen", Address, held);
      check("halt_fault_sticky", 64'(Fault), 64'd1);
      check("halt_no_push", 64'(InstrValid), 64'd0);
`else
      held = 64'h30;
      start_stream(64'h30, 2);
      pulse_redirect(64'h32);
      check("misalign_addr", Address, held);
      check("misalign_fault", 64'(Fault), 64'd0);
      InstrReady = 1'b1;
      wait_drain("misalign_drain");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface.
- Owns the program counter and drives Address into the read-only instruction memory. Waits the memory's access time, captures the 32-bit Data word, and queues it with its PC in a small prefetch buffer for decode.
- Decode pops entries with a valid/ready handshake.
- Branch/CBZ resolution redirects the PC and flushes everything fetched down the wrong path.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- WAIT_CYCLES, 2, clocks Address is held before Data is sampled; legal range 1..15. Covers the memory's 20 ns read time.
- BUF_DEPTH, 2, prefetch buffer entries; power of two, 2..8.

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Address  output  64  fetch address to instruction memory; always word aligned
- Data  input  32  instruction word returned by memory
- InstrOut  output  32  instruction at buffer head
- InstrPC  output  64  PC of InstrOut
- InstrValid  output  1  buffer non-empty
- InstrReady  input  1  decode accepts head this cycle
- Redirect  input  1  one-cycle pulse: taken branch, refetch from RedirectPC
- RedirectPC  input  64  new fetch target
- Fault  output  1  sticky alignment fault (FETCH_ALIGN_CHECK_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, any state):
  - Address=RESET_PC, wait counter=0, state=FETCH.
  - Buffer emptied; InstrValid=0, InstrOut=0, InstrPC=0, Fault=0.
  - Any in-flight fetch is abandoned.
- States: FETCH, FULL, HALT.
- FETCH:
  - Address held constant; counter increments each edge.
  - On the edge where counter==WAIT_CYCLES-1 and the buffer is not full: push {Address, Data}, Address<=Address+4, counter<=0.
  - If the buffer is full at that edge: go to FULL, with no push and no PC change.
- FULL:
  - Address held.
  - On the first edge with a free slot (including a pop on that same edge): push {Address, Data}, Address+=4, counter<=0, return to FETCH.
  - Data is re-sampled at that edge; Address has been stable for ≥WAIT_CYCLES, so it is valid.
- Latency: first InstrValid=1 is visible after the WAIT_CYCLES-th rising edge following Reset release. Steady-state throughput is one instruction per WAIT_CYCLES clocks.
- Buffer:
  - Circular FIFO with registered outputs.
  - Head is presented on InstrOut/InstrPC whenever InstrValid=1.
  - Pop occurs on an edge with InstrValid & InstrReady.
  - Push and pop on the same edge are allowed; occupancy is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo BUF_DEPTH; count range 0..BUF_DEPTH.
- InstrOut/InstrPC must not change while InstrValid=1 and InstrReady=0.
- Redirect (highest priority, non-Reset):
  - On the edge: buffer flushed (InstrValid=0 next cycle), Address<=RedirectPC, counter<=0, state<=FETCH.
  - Any push or pop on the same edge is discarded.
  - Redirect during FULL or mid-wait is legal.
- PC arithmetic is 64-bit unsigned; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.
- Data content is not inspected; undefined Data from an unmapped address is queued unchanged.
- HALT is reachable only with the optional feature:
  - Address holds, no pushes.
  - The buffer still drains through InstrReady.
  - Exit via Reset only; Redirect is ignored.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - Redirect with RedirectPC[1:0]!=0 sets Fault=1 (sticky) and enters HALT.
  - The buffer is flushed and Address is left at its pre-redirect value.
- Not defined:
  - RedirectPC[1:0] are forced to 00 when loaded.
  - Fault is constant 0 and HALT is unreachable.

Test Plan:
- Reset release, memory model loaded, WAIT_CYCLES=2, InstrReady=1 -> Address 0,4,8,... every 2 clocks. InstrOut sequence F84003E9@PC0, F84083EA@PC4, F84103EB@PC8; first InstrValid after 2nd edge.
- InstrReady=0, BUF_DEPTH=2 -> two entries (PC 0,4) queued, state FULL, Address held at 8, InstrOut stable at F84003E9. Raise InstrReady -> PC 8 captured on the pop edge, stream resumes without a gap or duplicate.
- Redirect pulse with RedirectPC=0x028 while buffer holds PC 0x10,0x14 -> InstrValid=0 next cycle. Next InstrOut=17FFFFFD at PC 0x028, followed by F80203ED at 0x02C.
- Redirect on the same edge as a scheduled push and a pop -> neither takes effect; first subsequent InstrPC equals RedirectPC.
- Reset asserted mid-wait with 1 entry queued -> immediately Address=RESET_PC, InstrValid=0; refetch from 0 after release.
- With FETCH_ALIGN_CHECK_EN: RedirectPC=0x032 -> Fault=1, Address frozen, later Redirect to 0x034 ignored. Without it -> fetch proceeds from 0x030 (Data F84203ED).
